// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: fetches 16-bit instructions and drives the
// memory-block and datapath control inputs through FETCH/DECODE/EXEC/WB.
module control_sequencer #(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic        CLK100MHZ,
    input  logic        RST,
    input  logic        start,
    input  logic [15:0] mb_data_out,
    input  logic        dp_zf_flag,
    output logic        mb_sel,
    output logic [7:0]  mb_pc_addr,
    output logic [7:0]  mb_cu_addr,
    output logic        mb_mem_read,
    output logic        mb_mem_write,
    output logic [7:0]  dp_imm,
    output logic [1:0]  dp_sel,
    output logic [3:0]  dp_write_addr,
    output logic        dp_write,
    output logic [3:0]  dp_a_addr,
    output logic        dp_a_read,
    output logic [3:0]  dp_b_addr,
    output logic        dp_b_read,
    output logic [3:0]  dp_alu_sel,
    output logic        busy,
    output logic        halted
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALT
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      state;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic        z;

    logic [3:0]  new_op, new_rd, new_ra, new_rb;
    logic [7:0]  new_imm;
    logic [3:0]  ir_op, ir_rd, ir_ra, ir_rb;
    logic [7:0]  ir_imm;

    // DECODE looks at the incoming word to set up EXEC outputs one cycle early
    assign new_op  = mb_data_out[15:12];
    assign new_rd  = mb_data_out[11:8];
    assign new_ra  = mb_data_out[7:4];
    assign new_rb  = mb_data_out[3:0];
    assign new_imm = mb_data_out[7:0];

    assign ir_op  = ir[15:12];
    assign ir_rd  = ir[11:8];
    assign ir_ra  = ir[7:4];
    assign ir_rb  = ir[3:0];
    assign ir_imm = ir[7:0];

    assign mb_pc_addr = pc;

    // Outputs are registered: each branch sets the values for the state being entered
    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            pc            <= PC_RESET;
            ir            <= 16'h0000;
            z             <= 1'b0;
            mb_sel        <= 1'b0;
            mb_cu_addr    <= 8'h00;
            mb_mem_read   <= 1'b0;
            mb_mem_write  <= 1'b0;
            dp_imm        <= 8'h00;
            dp_sel        <= 2'd0;
            dp_write_addr <= 4'h0;
            dp_write      <= 1'b0;
            dp_a_addr     <= 4'h0;
            dp_a_read     <= 1'b0;
            dp_b_addr     <= 4'h0;
            dp_b_read     <= 1'b0;
            dp_alu_sel    <= 4'h0;
            busy          <= 1'b0;
            halted        <= 1'b0;
        end else begin
            mb_sel        <= 1'b0;
            mb_cu_addr    <= 8'h00;
            mb_mem_read   <= 1'b0;
            mb_mem_write  <= 1'b0;
            dp_imm        <= 8'h00;
            dp_sel        <= 2'd0;
            dp_write_addr <= 4'h0;
            dp_write      <= 1'b0;
            dp_a_addr     <= 4'h0;
            dp_a_read     <= 1'b0;
            dp_b_addr     <= 4'h0;
            dp_b_read     <= 1'b0;
            dp_alu_sel    <= 4'h0;
            busy          <= 1'b0;
            halted        <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= FETCH;
                        mb_mem_read <= 1'b1;
                        busy        <= 1'b1;
                    end
                end

                FETCH: begin
                    state <= DECODE;
                    busy  <= 1'b1;
                end

                DECODE: begin
                    ir    <= mb_data_out;
                    pc    <= pc + 8'd1;
                    state <= EXEC;
                    busy  <= 1'b1;
                    if (!new_op[3]) begin
                        dp_a_addr  <= new_ra;
                        dp_a_read  <= 1'b1;
                        dp_b_addr  <= new_rb;
                        dp_b_read  <= 1'b1;
                        dp_alu_sel <= {1'b0, new_op[2:0]};
                    end else begin
                        case (new_op)
                            OP_LDI: begin
                                dp_sel        <= 2'd0;
                                dp_imm        <= new_imm;
                                dp_write_addr <= new_rd;
                                dp_write      <= 1'b1;
                            end
                            OP_LD: begin
                                mb_sel      <= 1'b1;
                                mb_cu_addr  <= new_imm;
                                mb_mem_read <= 1'b1;
                            end
                            OP_ST: begin
                                dp_a_addr <= new_rd;
                                dp_a_read <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end

                EXEC: begin
                    busy <= 1'b1;
                    if (!ir_op[3]) begin
                        state         <= WB;
                        dp_a_addr     <= ir_ra;
                        dp_a_read     <= 1'b1;
                        dp_b_addr     <= ir_rb;
                        dp_b_read     <= 1'b1;
                        dp_alu_sel    <= {1'b0, ir_op[2:0]};
                        dp_sel        <= 2'd2;
                        dp_write_addr <= ir_rd;
                        dp_write      <= 1'b1;
                    end else begin
                        case (ir_op)
                            OP_LD: begin
                                state         <= WB;
                                mb_sel        <= 1'b1;
                                mb_cu_addr    <= ir_imm;
                                mb_mem_read   <= 1'b1;
                                dp_sel        <= 2'd1;
                                dp_write_addr <= ir_rd;
                                dp_write      <= 1'b1;
                            end
                            OP_ST: begin
                                state        <= WB;
                                dp_a_addr    <= ir_rd;
                                dp_a_read    <= 1'b1;
                                mb_sel       <= 1'b1;
                                mb_cu_addr   <= ir_imm;
                                mb_mem_write <= 1'b1;
                            end
                            OP_HALT: begin
                                state  <= HALT;
                                busy   <= 1'b0;
                                halted <= 1'b1;
                            end
                            OP_JMP: begin
                                pc          <= ir_imm;
                                state       <= FETCH;
                                mb_mem_read <= 1'b1;
                            end
                            OP_JZ: begin
                                if (z) begin
                                    pc <= ir_imm;
                                end
                                state       <= FETCH;
                                mb_mem_read <= 1'b1;
                            end
                            default: begin
                                state       <= FETCH;
                                mb_mem_read <= 1'b1;
                            end
                        endcase
                    end
                end

                WB: begin
                    // Only ALU instructions reach WB with op[3] clear, so only they touch Z
                    if (!ir_op[3]) begin
                        z <= dp_zf_flag;
                    end
                    state       <= FETCH;
                    mb_mem_read <= 1'b1;
                    busy        <= 1'b1;
                end

                HALT: begin
                    halted <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Instruction-level control unit driving the memory-block (`mb_*`) and datapath (`dp_*`) control inputs of the full datapath, replacing hand-driven stimulus. It fetches 16-bit instructions from memory via the PC port, decodes them, and sequences register-file reads and writes, ALU selection, and memory load/store through the CU address port. It is a multi-cycle FSM with no pipelining and sits directly beside the full datapath in the top level.

## Interface
- `PC_RESET`, default 8'h00: PC value loaded on reset.
- `CLK100MHZ`  in  1  system clock, rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `start`  in  1  leave IDLE and begin fetching; sampled in IDLE only.
- `mb_data_out`  in  16  memory read data, valid the cycle after `mb_mem_read` is asserted with a stable address.
- `dp_zf_flag`  in  1  ALU zero flag (combinational from current ALU inputs).
- `mb_sel`  out  1  0 = memory addressed by `mb_pc_addr`, 1 = by `mb_cu_addr`.
- `mb_pc_addr`  out  8  program counter.
- `mb_cu_addr`  out  8  data address for LD/ST.
- `mb_mem_read`, `mb_mem_write`  out  1 each  memory strobes.
- `dp_imm`  out  8  immediate to datapath.
- `dp_sel`  out  2  write-back mux: 0 = imm, 1 = memory, 2 = ALU, 3 unused.
- `dp_write_addr`  out  4;  `dp_write`  out  1  register write port.
- `dp_a_addr`  out  4;  `dp_a_read`  out  1  read port A.
- `dp_b_addr`  out  4;  `dp_b_read`  out  1  read port B.
- `dp_alu_sel`  out  4  ALU operation.
- `busy`  out  1  high in every state except IDLE and HALT.
- `halted`  out  1  high in HALT.

## Operation
- Instruction fields: `op`=[15:12], `rd`=[11:8], `ra`=[7:4], `rb`=[3:0], `imm`=[7:0].
- Opcodes:
  - 0x0–0x7 ALU: rd = ra OP rb, with `dp_alu_sel`={1'b0,op[2:0]}.
  - 0x8 LDI: rd = imm.
  - 0x9 LD: rd = mem[imm].
  - 0xA ST: mem[imm] = rd.
  - 0xB JMP: PC = imm.
  - 0xC JZ: PC = imm if Z.
  - 0xF HALT.
  - 0xD, 0xE: NOP.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- Every output not listed for a state is 0. `mb_pc_addr` always shows PC.
- IDLE: wait for `start`=1, then go to FETCH.
- FETCH: `mb_sel`=0, `mb_mem_read`=1. Go to DECODE.
- DECODE: IR ← `mb_data_out`; PC ← PC+1, mod 256 (0xFF wraps to 0x00). Go to EXEC.
- EXEC:
  - ALU: `dp_a_addr`=ra, `dp_b_addr`=rb, both reads = 1, `dp_alu_sel` set. Go to WB.
  - LDI: `dp_sel`=0, `dp_imm`=imm, `dp_write_addr`=rd, `dp_write`=1. Go to FETCH.
  - LD: `mb_sel`=1, `mb_cu_addr`=imm, `mb_mem_read`=1. Go to WB.
  - ST: `dp_a_addr`=rd, `dp_a_read`=1. Go to WB.
  - JMP: PC ← imm. Go to FETCH.
  - JZ: PC ← imm if Z=1. Go to FETCH.
  - NOP: go to FETCH.
  - HALT: go to HALT.
- WB:
  - ALU: hold EXEC read/ALU signals; `dp_sel`=2, `dp_write_addr`=rd, `dp_write`=1; Z ← `dp_zf_flag`.
  - LD: hold `mb_sel`/`mb_cu_addr`/`mb_mem_read`; `dp_sel`=1, `dp_write_addr`=rd, `dp_write`=1.
  - ST: hold the A read; `mb_sel`=1, `mb_cu_addr`=imm, `mb_mem_write`=1.
  - All go to FETCH.
- Z flag: internal register, updated only in ALU WB. LD, LDI and ST do not change it.
- HALT: terminal state; only `RST` exits. `start` is ignored.
- `mb_mem_read` and `mb_mem_write` are never high in the same cycle.

## Timing
- Reset (async): state=IDLE, PC=`PC_RESET`, IR=0, Z=0. All outputs 0 except `mb_pc_addr`=`PC_RESET`.
- Reset asserted mid-instruction aborts it. Any write strobe deasserts immediately, with no partial write.
- Cycles per instruction, counted from FETCH:
  - ALU, LD, ST: 4.
  - LDI, JMP, JZ, NOP: 3.
  - HALT: 3 cycles to enter HALT.
- `start` is level-sensitive. It takes effect on the first rising edge seen in IDLE; FETCH begins the next cycle.
- JZ tests Z as it was latched by the most recent completed ALU instruction.
- Register writes occur on the rising edge ending the write cycle. A following instruction's EXEC read sees the new value.

## Test plan
- Reset/start: assert RST, hold `start`=0 for 3 cycles → all outputs 0, `busy`=0. Pulse `start` → FETCH next cycle with `mb_pc_addr`=0x00, `mb_mem_read`=1.
- LDI/ALU: program `8105`, `8203`, `0312`, `F000` with `dp_alu_sel` 0 = add → `dp_write` to r1=0x05 and r2=0x03. ALU WB shows `dp_sel`=2, `dp_write_addr`=3. `halted`=1 after 13 cycles from first FETCH.
- LD/ST: mem[0x20]=0xBEEF; program `9420`, `A421`, `F000` → LD WB shows `mb_sel`=1, `mb_cu_addr`=0x20, `dp_sel`=1. ST WB shows `mb_mem_write`=1, `mb_cu_addr`=0x21, `dp_a_addr`=4. mem[0x21]=0xBEEF.
- JZ: ALU op whose result is 0 (bench drives `dp_zf_flag`=1), then `C010` → next FETCH address 0x10. Repeat with `dp_zf_flag`=0 → fall-through to PC+1.
- PC wrap: `PC_RESET`=0xFF with NOP at 0xFF → next fetch at 0x00.
- Reset mid-ST: assert RST during ST WB → `mb_mem_write` drops asynchronously, memory unchanged; restart refetches from `PC_RESET`.
